// File: rtl/gpio_irq_pkg.sv
// Shared constants for the gpio_irq peripheral: per-port register offsets and port width.
package gpio_irq_pkg;

  localparam int PORT_W = 8;

  localparam logic [2:0] REG_OUT  = 3'd0;
  localparam logic [2:0] REG_DIR  = 3'd1;
  localparam logic [2:0] REG_IN   = 3'd2;
  localparam logic [2:0] REG_RISE = 3'd3;
  localparam logic [2:0] REG_FALL = 3'd4;
  localparam logic [2:0] REG_STAT = 3'd5;
  localparam logic [2:0] REG_IEN  = 3'd6;
  localparam logic [2:0] REG_TGL  = 3'd7;

endpackage

// File: rtl/gpio_irq_port.sv
// One 8-bit GPIO port: output/direction latches, pin synchroniser, edge capture,
// sticky status with W1C, local interrupt and unregistered read mux.
module gpio_irq_port
  import gpio_irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [2:0]        off,
  input  logic [PORT_W-1:0] din,
  input  logic [PORT_W-1:0] pin,
  output logic [PORT_W-1:0] out,
  output logic [PORT_W-1:0] dir,
  output logic [PORT_W-1:0] rd_data,
  output logic              irq_o
);

  logic [PORT_W-1:0] out_q, out_d;
  logic [PORT_W-1:0] dir_q, dir_d;
  logic [PORT_W-1:0] rise_q, rise_d;
  logic [PORT_W-1:0] fall_q, fall_d;
  logic [PORT_W-1:0] stat_q, stat_d;
  logic [PORT_W-1:0] ien_q, ien_d;
  logic [PORT_W-1:0] prev_q;
  logic [PORT_W-1:0] sync_q [SYNC_STAGES];
  logic [PORT_W-1:0] in_s, set_s, clr_s;

  assign in_s  = sync_q[SYNC_STAGES-1];
  assign set_s = (in_s & ~prev_q & rise_q) | (~in_s & prev_q & fall_q);

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    rise_d = rise_q;
    fall_d = fall_q;
    ien_d  = ien_q;
    clr_s  = '0;
    if (wr_en) begin
      case (off)
        REG_OUT:  out_d  = din;
        REG_DIR:  dir_d  = din;
        REG_RISE: rise_d = din;
        REG_FALL: fall_d = din;
        REG_STAT: clr_s  = din;
        REG_IEN:  ien_d  = din;
        REG_TGL:  out_d  = out_q ^ din;
        default:  ;
      endcase
    end
    // A new edge in the same cycle as its W1C keeps the bit set.
    stat_d = (stat_q & ~clr_s) | set_s;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= '0;
      dir_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      stat_q <= '0;
      ien_q  <= '0;
      prev_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      stat_q    <= stat_d;
      ien_q     <= ien_d;
      prev_q    <= in_s;
      sync_q[0] <= pin;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_comb begin
    rd_data = '0;
    case (off)
      REG_OUT:  rd_data = out_q;
      REG_DIR:  rd_data = dir_q;
      REG_IN:   rd_data = in_s;
      REG_RISE: rd_data = rise_q;
      REG_FALL: rd_data = fall_q;
      REG_STAT: rd_data = stat_q;
      REG_IEN:  rd_data = ien_q;
      default:  rd_data = '0;
    endcase
  end

  assign out   = out_q;
  assign dir   = dir_q;
  assign irq_o = |(stat_q & ien_q);

endmodule

// File: rtl/gpio_irq.sv
// GPIO peripheral top: port decode, NPORTS port instances, registered read data
// and registered OR of the per-port interrupts.
module gpio_irq
  import gpio_irq_pkg::*;
#(
  parameter int NPORTS      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cs,
  input  logic                     we,
  input  logic [5:0]               addr,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  input  logic [PORT_W*NPORTS-1:0] gpio_i,
  output logic [PORT_W*NPORTS-1:0] gpio_o,
  output logic [PORT_W*NPORTS-1:0] gpio_oe,
  output logic                     irq
);

  logic [2:0]        port_sel;
  logic [2:0]        off;
  logic [PORT_W-1:0] port_rd [NPORTS];
  logic [NPORTS-1:0] port_irq;
  logic [7:0]        dout_q, dout_d;
  logic              irq_q, irq_d;

  assign port_sel = addr[5:3];
  assign off      = addr[2:0];

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    gpio_irq_port #(.SYNC_STAGES(SYNC_STAGES)) u_port (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (cs & we & (port_sel == 3'(p))),
      .off     (off),
      .din     (din),
      .pin     (gpio_i[PORT_W*p +: PORT_W]),
      .out     (gpio_o[PORT_W*p +: PORT_W]),
      .dir     (gpio_oe[PORT_W*p +: PORT_W]),
      .rd_data (port_rd[p]),
      .irq_o   (port_irq[p])
    );
  end

  // Unpopulated port indices fall through to zero.
  always_comb begin
    dout_d = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (port_sel == 3'(p)) dout_d = port_rd[p];
    end
    irq_d = |port_irq;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      irq_q  <= irq_d;
    end
  end

  assign dout = dout_q;
  assign irq  = irq_q;

endmodule
